booth_mult_pipe: RTL and testbench
==================================

// Module: booth_mult_pipe
// PURPOSE
//  Fully pipelined radix-4 (modified) Booth multiplier. It generalises the single radix-2 Booth step
//  into a complete WIDTH x WIDTH multiplier with one Booth digit per stage.
//  Adds per-transaction signed/unsigned mode, valid/ready backpressure, a tag passthrough and a sync flush.
//  It sits in the DCT/quantiser datapath, feeding coefficient products to the accumulators.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 4
//  TAG_W  4  width of the user tag carried alongside each product
//  (derived) NSTEP = WIDTH/2+1  number of Booth digits, which is also the number of pipeline stages
// PORTS
//  clk             in   1          rising-edge clock
//  nrst            in   1          asynchronous active-low reset
//  flush           in   1          synchronous; drops every in-flight transaction
//  din_multiplicand in  WIDTH      operand A
//  din_multiplier  in   WIDTH      operand B (the Booth-recoded operand)
//  din_signed      in   1          1: both operands are two's complement; 0: both are unsigned
//  din_tag         in   TAG_W      user tag, returned with the product
//  din_valid       in   1          input transaction valid
//  din_ready       out  1          input can be accepted this cycle
//  dout_product    out  2*WIDTH    A*B (signed or unsigned, according to the captured mode)
//  dout_tag        out  TAG_W      tag of the transaction being output
//  dout_valid      out  1          output valid
//  dout_ready      in   1          downstream accepts the output
// BEHAVIOUR
//  - Reset (nrst=0, async): every stage valid bit and dout_valid go to 0. The data registers are not reset;
//    dout_product and dout_tag are don't-care while dout_valid=0.
//  - Operand extension: each operand is extended to WIDTH+2 bits.
//    - Sign-extended if din_signed=1, zero-extended otherwise.
//    - The multiplier then yields NSTEP Booth digits from the triples {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
//  - Digit map (triple -> partial product):
//    - 000 and 111 -> 0
//    - 001 and 010 -> +A
//    - 011 -> +2A
//    - 100 -> -2A
//    - 101 and 110 -> -A
//    - Partial product i is weighted by 4^i. It is formed at 2*WIDTH+2 bits, sign-extended, and negated
//      in two's complement.
//  - Accumulation: the accumulator is 2*WIDTH+2 bits wide and carries no saturation. The product is
//    accumulator[2*WIDTH-1:0], which is exact for both modes.
//  - Pipeline: stage i registers {sum of digits 0..i, A_ext, B_ext, tag, valid}. Stage NSTEP-1 drives the dout_* outputs.
//    - Latency is exactly NSTEP cycles from the accepting edge to dout_valid=1 when there is no stall.
//    - Throughput is 1 transaction/cycle.
//  - Handshake: stall = dout_valid & ~dout_ready.
//    - din_ready = ~stall (combinational from dout_ready).
//    - Every stage holds its contents while stall=1 and advances otherwise (global enable; bubbles are not compressed).
//    - A transaction is accepted on a rising edge with din_valid & din_ready.
//    - A transaction is consumed on a rising edge with dout_valid & dout_ready.
//    - dout_* must stay stable while dout_valid=1 and dout_ready=0.
//  - Simultaneous accept and consume in one cycle is legal: the pipeline shifts and stays full.
//  - Flush: every valid bit is cleared at the next edge, regardless of stall. A din transaction presented
//    in the same cycle is dropped. din_ready is unaffected.
//  - Mode switching: din_signed is captured per transaction, so mixed modes in flight are legal.
//  - Reset asserted mid-operation: the pipeline empties immediately, and no stale dout_valid appears after release.
// TESTING
//  1. WIDTH=8, signed: -128 * -128 -> 16384 (0x4000); -128 * 127 -> -16256 (0xC080); -1 * -1 -> 1.
//  2. WIDTH=8, unsigned: 255 * 255 -> 65025 (0xFE01); 0 * 200 -> 0; 128 * 2 -> 256.
//  3. Back-to-back issue, dout_ready=1 constantly: 20 random transactions with tags 0..F.
//     -> Products appear on consecutive cycles, first at +5 cycles (NSTEP=5), with tags in order.
//  4. Backpressure: hold dout_ready=0 for 7 cycles while the pipeline is full.
//     -> din_ready=0 and dout stable; once released, nothing is lost or duplicated.
//  5. Flush with 3 transactions in flight plus 1 presented -> no further dout_valid until a new issue,
//     which then completes at +NSTEP cycles.
//  6. Assert nrst mid-stream -> dout_valid=0 immediately. Parametric sweep WIDTH in {4, 8, 16}, exhaustive
//     for WIDTH=4 in both modes against a reference model.

Source files
------------

// File: rtl/booth_mult_pipe.sv
// Fully pipelined radix-4 Booth multiplier: one Booth digit per stage, per-transaction signed/unsigned mode,
// valid/ready backpressure with a global stall, tag passthrough and synchronous flush.
module booth_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   din_multiplicand,
  input  logic [WIDTH-1:0]   din_multiplier,
  input  logic               din_signed,
  input  logic [TAG_W-1:0]   din_tag,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [2*WIDTH-1:0] dout_product,
  output logic [TAG_W-1:0]   dout_tag,
  output logic               dout_valid,
  input  logic               dout_ready
);

  localparam int NSTEP = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH + 2;

  // Booth triple {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0.
  function automatic logic [2:0] booth_triple(input logic [EW-1:0] b, input int idx);
    logic [EW:0] pad;
    pad = {b, 1'b0} >> (2 * idx);
    return pad[2:0];
  endfunction

  function automatic logic [PW-1:0] booth_pp(input logic [EW-1:0] a, input logic [2:0] trip,
                                             input int idx);
    logic [PW-1:0] a_sx;
    logic [PW-1:0] mag;
    logic          neg;
    a_sx = {{(PW-EW){a[EW-1]}}, a};
    mag  = '0;
    neg  = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = a_sx;
      3'b011:         mag = a_sx << 1;
      3'b100: begin
        mag = a_sx << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = a_sx;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    if (neg) mag = -mag;
    return mag << (2 * idx);
  endfunction

  logic [EW-1:0]      a_in;
  logic [EW-1:0]      b_in;
  logic               stall;
  logic [NSTEP-1:0]   vld_q;
  logic [PW-1:0]      acc_q [NSTEP-1];
  logic [EW-1:0]      a_q   [NSTEP-1];
  logic [EW-1:0]      b_q   [NSTEP-1];
  logic [TAG_W-1:0]   tag_q [NSTEP];
  logic [2*WIDTH-1:0] prod_q;

  always_comb begin
    a_in = din_signed ? {{2{din_multiplicand[WIDTH-1]}}, din_multiplicand}
                      : {2'b00, din_multiplicand};
    b_in = din_signed ? {{2{din_multiplier[WIDTH-1]}}, din_multiplier}
                      : {2'b00, din_multiplier};
  end

  assign stall        = vld_q[NSTEP-1] & ~dout_ready;
  assign din_ready    = ~stall;
  assign dout_valid   = vld_q[NSTEP-1];
  assign dout_tag     = tag_q[NSTEP-1];
  assign dout_product = prod_q;

  // Flush overrides the stall so that a blocked output is dropped as well.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= {vld_q[NSTEP-2:0], din_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      acc_q[0] <= booth_pp(a_in, booth_triple(b_in, 0), 0);
      a_q[0]   <= a_in;
      b_q[0]   <= b_in;
      tag_q[0] <= din_tag;
      for (int i = 1; i < NSTEP - 1; i++) begin
        acc_q[i] <= acc_q[i-1] + booth_pp(a_q[i-1], booth_triple(b_q[i-1], i), i);
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
      for (int i = 1; i < NSTEP; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // The two guard bits are dropped here; the low 2*WIDTH bits are exact in both modes.
      prod_q <= (2*WIDTH)'(acc_q[NSTEP-2]
                + booth_pp(a_q[NSTEP-2], booth_triple(b_q[NSTEP-2], NSTEP-1), NSTEP-1));
    end
  end

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed bench for booth_mult_pipe: WIDTH=8 main instance, WIDTH=4 exhaustive sweep, WIDTH=16 spot checks.
module tb_booth_mult_pipe;

  localparam int NSTEP8  = 5;
  localparam int NSTEP4  = 3;
  localparam int NSTEP16 = 9;

  logic clk = 1'b0;
  logic nrst;
  logic flush;

  logic [7:0]  a8, b8;
  logic        s8, v8, dr8;
  logic [3:0]  t8;
  logic        din_ready8, ov8;
  logic [15:0] p8;
  logic [3:0]  ot8;

  logic [3:0]  a4, b4;
  logic        s4, v4, dr4;
  logic [3:0]  t4;
  logic        din_ready4, ov4;
  logic [7:0]  p4;
  logic [3:0]  ot4;

  logic [15:0] a16, b16;
  logic        s16, v16, dr16;
  logic [3:0]  t16;
  logic        din_ready16, ov16;
  logic [31:0] p16;
  logic [3:0]  ot16;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  ra [20];
  logic [7:0]  rb [20];
  logic        rs [20];
  logic [15:0] exp_p_q [$];
  logic [3:0]  exp_t_q [$];
  logic [15:0] d16a [4];
  logic [15:0] d16b [4];
  logic        d16s [4];
  logic [31:0] d16p [4];
  int          j;
  int          consumed;
  logic [8:0]  n9;

  always #5 clk = ~clk;

  booth_mult_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .din_multiplicand(a8), .din_multiplier(b8), .din_signed(s8), .din_tag(t8),
    .din_valid(v8), .din_ready(din_ready8),
    .dout_product(p8), .dout_tag(ot8), .dout_valid(ov8), .dout_ready(dr8)
  );

  booth_mult_pipe #(.WIDTH(4), .TAG_W(4)) u4 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .din_multiplicand(a4), .din_multiplier(b4), .din_signed(s4), .din_tag(t4),
    .din_valid(v4), .din_ready(din_ready4),
    .dout_product(p4), .dout_tag(ot4), .dout_valid(ov4), .dout_ready(dr4)
  );

  booth_mult_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .nrst(nrst), .flush(flush),
    .din_multiplicand(a16), .din_multiplier(b16), .din_signed(s16), .din_tag(t16),
    .din_valid(v16), .din_ready(din_ready16),
    .dout_product(p16), .dout_tag(ot16), .dout_valid(ov16), .dout_ready(dr16)
  );

  // Plain integer reference: operands are interpreted per mode, product truncated to 2*w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint ai, bi;
    ai = longint'(a);
    bi = longint'(b);
    if (s && a[w-1]) ai = ai - (longint'(1) << w);
    if (s && b[w-1]) bi = bi - (longint'(1) << w);
    return 32'((ai * bi) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                               input logic [3:0] tag, input logic v);
    a8 = a;
    b8 = b;
    s8 = s;
    t8 = tag;
    v8 = v;
  endtask

  // Single issue; dout_valid must rise on the NSTEP-th edge counting the accepting edge.
  task automatic runOne8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] tag, input logic [15:0] exp);
    applyStimulus(a, b, s, tag, 1'b1);
    step();
    v8 = 1'b0;
    repeat (NSTEP8 - 2) step();
    checkOutput("latency_early", {31'd0, ov8}, 32'd0);
    step();
    checkOutput("latency_valid", {31'd0, ov8}, 32'd1);
    checkOutput("single_product", {16'd0, p8}, {16'd0, exp});
    checkOutput("single_tag", {28'd0, ot8}, {28'd0, tag});
    step();
  endtask

  initial begin
    $display("[TB] booth_mult_pipe bench starting");
    nrst = 1'b0; flush = 1'b0;
    applyStimulus(8'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    dr8 = 1'b1;
    a4 = '0; b4 = '0; s4 = 1'b0; t4 = '0; v4 = 1'b0; dr4 = 1'b1;
    a16 = '0; b16 = '0; s16 = 1'b0; t16 = '0; v16 = 1'b0; dr16 = 1'b1;
    #1;
    checkOutput("reset_valid8", {31'd0, ov8}, 32'd0);
    checkOutput("reset_ready8", {31'd0, din_ready8}, 32'd1);
    checkOutput("reset_valid4", {31'd0, ov4}, 32'd0);
    checkOutput("reset_valid16", {31'd0, ov16}, 32'd0);
    step();
    step();
    nrst = 1'b1;
    step();

    // Directed corner products for both modes.
    runOne8(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    runOne8(8'h80, 8'h7F, 1'b1, 4'h2, 16'hC080);
    runOne8(8'hFF, 8'hFF, 1'b1, 4'h3, 16'h0001);
    runOne8(8'hFF, 8'hFF, 1'b0, 4'h4, 16'hFE01);
    runOne8(8'h00, 8'hC8, 1'b0, 4'h5, 16'h0000);
    runOne8(8'h80, 8'h02, 1'b0, 4'h6, 16'h0100);

    // Back-to-back stream of 20 mixed-mode transactions.
    for (int i = 0; i < 20; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
      rs[i] = 1'($urandom);
    end
    for (int k = 0; k < 20 + NSTEP8; k++) begin
      if (k >= NSTEP8) begin
        checkOutput("stream_valid", {31'd0, ov8}, 32'd1);
        checkOutput("stream_product", {16'd0, p8},
                    ref_prod(8, {8'd0, ra[k-NSTEP8]}, {8'd0, rb[k-NSTEP8]}, rs[k-NSTEP8]));
        checkOutput("stream_tag", {28'd0, ot8}, {28'd0, 4'(k - NSTEP8)});
      end else begin
        checkOutput("stream_idle", {31'd0, ov8}, 32'd0);
      end
      if (k < 20) applyStimulus(ra[k], rb[k], rs[k], 4'(k), 1'b1);
      else v8 = 1'b0;
      step();
    end
    checkOutput("stream_drained", {31'd0, ov8}, 32'd0);

    // Backpressure: fill with dout_ready low, hold 7 cycles, then drain.
    dr8 = 1'b0;
    j = 0;
    for (int c = 0; c < 20 && din_ready8; c++) begin
      applyStimulus(8'(j * 37 + 3), 8'(j * 11 + 200), j[0], 4'(j + 8), 1'b1);
      #1;
      if (din_ready8) begin
        exp_p_q.push_back(16'(ref_prod(8, {8'd0, a8}, {8'd0, b8}, s8)));
        exp_t_q.push_back(t8);
        j++;
      end
      step();
    end
    checkOutput("bp_fill_count", 32'(j), 32'(NSTEP8));
    for (int c = 0; c < 7; c++) begin
      checkOutput("bp_din_ready", {31'd0, din_ready8}, 32'd0);
      checkOutput("bp_hold_valid", {31'd0, ov8}, 32'd1);
      checkOutput("bp_hold_product", {16'd0, p8}, {16'd0, exp_p_q[0]});
      checkOutput("bp_hold_tag", {28'd0, ot8}, {28'd0, exp_t_q[0]});
      step();
    end
    dr8 = 1'b1;
    consumed = 0;
    for (int c = 0; c < 40 && (j < 7 || exp_p_q.size() > 0); c++) begin
      if (j < 7) applyStimulus(8'(j * 37 + 3), 8'(j * 11 + 200), j[0], 4'(j + 8), 1'b1);
      else v8 = 1'b0;
      #1;
      if (v8 && din_ready8) begin
        exp_p_q.push_back(16'(ref_prod(8, {8'd0, a8}, {8'd0, b8}, s8)));
        exp_t_q.push_back(t8);
        j++;
      end
      if (ov8 && dr8) begin
        if (exp_p_q.size() > 0) begin
          checkOutput("bp_drain_product", {16'd0, p8}, {16'd0, exp_p_q.pop_front()});
          checkOutput("bp_drain_tag", {28'd0, ot8}, {28'd0, exp_t_q.pop_front()});
          consumed++;
        end else begin
          checkOutput("bp_extra_output", {31'd0, ov8}, 32'd0);
        end
      end
      step();
    end
    v8 = 1'b0;
    checkOutput("bp_consumed", 32'(consumed), 32'd7);
    checkOutput("bp_queue_empty", 32'(exp_p_q.size()), 32'd0);
    checkOutput("bp_after_valid", {31'd0, ov8}, 32'd0);

    // Flush with three in flight plus one presented.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'(k + 5), 8'(k + 9), 1'b0, 4'(k), 1'b1);
      step();
    end
    applyStimulus(8'h33, 8'h44, 1'b0, 4'hF, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_din_ready", {31'd0, din_ready8}, 32'd1);
    step();
    flush = 1'b0;
    v8 = 1'b0;
    for (int k = 0; k < NSTEP8 + 2; k++) begin
      checkOutput("flush_quiet", {31'd0, ov8}, 32'd0);
      step();
    end
    runOne8(8'h0C, 8'h0D, 1'b0, 4'hA, 16'h009C);

    // Asynchronous reset while the output is valid.
    for (int k = 0; k < NSTEP8; k++) begin
      applyStimulus(8'(k + 1), 8'h03, 1'b1, 4'(k), 1'b1);
      step();
    end
    checkOutput("prereset_valid", {31'd0, ov8}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, ov8}, 32'd0);
    v8 = 1'b0;
    step();
    nrst = 1'b1;
    for (int k = 0; k < NSTEP8 + 2; k++) begin
      checkOutput("postreset_quiet", {31'd0, ov8}, 32'd0);
      step();
    end

    // WIDTH=4 exhaustive sweep in both modes, streamed back to back.
    for (int k = 0; k < 512 + NSTEP4; k++) begin
      if (k >= NSTEP4) begin
        n9 = 9'(k - NSTEP4);
        checkOutput("w4_valid", {31'd0, ov4}, 32'd1);
        checkOutput("w4_product", {24'd0, p4},
                    ref_prod(4, {12'd0, n9[7:4]}, {12'd0, n9[3:0]}, n9[8]));
        checkOutput("w4_tag", {28'd0, ot4}, {28'd0, n9[3:0]});
      end
      if (k < 512) begin
        n9 = 9'(k);
        a4 = n9[7:4]; b4 = n9[3:0]; s4 = n9[8]; t4 = n9[3:0]; v4 = 1'b1;
      end else begin
        v4 = 1'b0;
      end
      step();
    end
    checkOutput("w4_drained", {31'd0, ov4}, 32'd0);

    // WIDTH=16 hand-computed vectors.
    d16a[0] = 16'h8000; d16b[0] = 16'h8000; d16s[0] = 1'b1; d16p[0] = 32'h4000_0000;
    d16a[1] = 16'hFFFF; d16b[1] = 16'hFFFF; d16s[1] = 1'b0; d16p[1] = 32'hFFFE_0001;
    d16a[2] = 16'hFFFF; d16b[2] = 16'h0007; d16s[2] = 1'b1; d16p[2] = 32'hFFFF_FFF9;
    d16a[3] = 16'h1234; d16b[3] = 16'h0010; d16s[3] = 1'b0; d16p[3] = 32'h0001_2340;
    for (int k = 0; k < 4 + NSTEP16; k++) begin
      if (k >= NSTEP16) begin
        checkOutput("w16_valid", {31'd0, ov16}, 32'd1);
        checkOutput("w16_product", p16, d16p[k-NSTEP16]);
        checkOutput("w16_tag", {28'd0, ot16}, {28'd0, 4'(k - NSTEP16)});
      end else begin
        checkOutput("w16_idle", {31'd0, ov16}, 32'd0);
      end
      if (k < 4) begin
        a16 = d16a[k]; b16 = d16b[k]; s16 = d16s[k]; t16 = 4'(k); v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
